f_fetch_npc: RTL and testbench

Fetch-stage PC register, next-PC selector and F/D pipeline register for the five-stage MIPS core. Consumes the D-stage branch decision (`d_judge`) and jump controls, computes the next fetch address with one architectural delay slot, and latches the fetched instruction and its PC into the F/D register for decode. It also flags instruction-address errors and keeps branch statistics counters for verification.

---
 rtl/f_fetch_npc_if.sv | 29 ++
 rtl/f_fetch_npc.sv | 85 ++++++++
 tb/tb_f_fetch_npc.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/f_fetch_npc_if.sv
// Fetch-stage bundle: D-stage control in, instruction-memory address/data,
// F/D register contents and branch statistics out.
interface f_fetch_npc_if;
    logic        stall;
    logic [31:0] f_instr;
    logic [1:0]  d_npc_op;
    logic        d_judge;
    logic [15:0] d_imm16;
    logic [25:0] d_imm26;
    logic [31:0] d_rs_data;
    logic [31:0] f_pc;
    logic        f_adel;
    logic [31:0] fd_instr;
    logic [31:0] fd_pc;
    logic        fd_valid;
    logic        fd_adel;
    logic [31:0] br_cnt;
    logic [31:0] br_taken_cnt;

    modport master (
        output stall, f_instr, d_npc_op, d_judge, d_imm16, d_imm26, d_rs_data,
        input  f_pc, f_adel, fd_instr, fd_pc, fd_valid, fd_adel, br_cnt, br_taken_cnt
    );

    modport slave (
        input  stall, f_instr, d_npc_op, d_judge, d_imm16, d_imm26, d_rs_data,
        output f_pc, f_adel, fd_instr, fd_pc, fd_valid, fd_adel, br_cnt, br_taken_cnt
    );
endinterface

// File: rtl/f_fetch_npc.sv
// Fetch-stage PC register and next-PC selection with one delay slot,
// F/D pipeline register, instruction-address error flag and branch counters.
module f_fetch_npc #(
    parameter logic [31:0] PC_RESET = 32'h0000_3000,
    parameter logic [31:0] IM_LO    = 32'h0000_3000,
    parameter logic [31:0] IM_HI    = 32'h0000_6FFC
) (
    input  logic         clk,
    input  logic         reset,
    f_fetch_npc_if.slave bus
);

    typedef enum logic [1:0] {
        NPC_SEQ    = 2'd0,
        NPC_BRANCH = 2'd1,
        NPC_JUMP   = 2'd2,
        NPC_JREG   = 2'd3
    } npc_op_e;

    logic [31:0] pc_q;
    logic [31:0] fd_instr_q;
    logic [31:0] fd_pc_q;
    logic        fd_valid_q;
    logic        fd_adel_q;
    logic [31:0] br_cnt_q;
    logic [31:0] br_taken_q;

    npc_op_e     op;
    logic [31:0] seq_pc;
    logic [31:0] fd_seq_pc;
    logic [31:0] br_off;
    logic [31:0] npc;
    logic        adel;

    always_comb begin
        // D controls only count for a real, non-stalled instruction in F/D
        op        = (fd_valid_q && !bus.stall) ? npc_op_e'(bus.d_npc_op) : NPC_SEQ;
        seq_pc    = pc_q + 32'd4;
        fd_seq_pc = fd_pc_q + 32'd4;
        br_off    = {{14{bus.d_imm16[15]}}, bus.d_imm16, 2'b00};
        npc       = seq_pc;
        case (op)
            NPC_SEQ:    npc = seq_pc;
            NPC_BRANCH: npc = bus.d_judge ? (fd_seq_pc + br_off) : seq_pc;
            NPC_JUMP:   npc = {fd_seq_pc[31:28], bus.d_imm26, 2'b00};
            NPC_JREG:   npc = bus.d_rs_data;
            default:    npc = seq_pc;
        endcase
        adel = (pc_q[1:0] != 2'b00) || (pc_q < IM_LO) || (pc_q > IM_HI);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q       <= PC_RESET;
            fd_instr_q <= '0;
            fd_pc_q    <= '0;
            fd_valid_q <= 1'b0;
            fd_adel_q  <= 1'b0;
            br_cnt_q   <= '0;
            br_taken_q <= '0;
        end else if (!bus.stall) begin
            pc_q       <= npc;
            fd_pc_q    <= pc_q;
            fd_valid_q <= 1'b1;
            fd_adel_q  <= adel;
            fd_instr_q <= adel ? '0 : bus.f_instr;
            if (op == NPC_BRANCH) begin
                br_cnt_q <= br_cnt_q + 32'd1;
                if (bus.d_judge) begin
                    br_taken_q <= br_taken_q + 32'd1;
                end
            end
        end
    end

    assign bus.f_pc         = pc_q;
    assign bus.f_adel       = adel;
    assign bus.fd_instr     = fd_instr_q;
    assign bus.fd_pc        = fd_pc_q;
    assign bus.fd_valid     = fd_valid_q;
    assign bus.fd_adel      = fd_adel_q;
    assign bus.br_cnt       = br_cnt_q;
    assign bus.br_taken_cnt = br_taken_q;

endmodule

// File: tb/tb_f_fetch_npc.sv
// Directed bench for f_fetch_npc: sequential fetch, branches, jumps,
// stalls, address errors and asynchronous reset.
module tb_f_fetch_npc;

    logic clk;
    logic reset;
    int unsigned n_checks;
    int unsigned n_pass;

    f_fetch_npc_if bus ();

    f_fetch_npc #(
        .PC_RESET(32'h0000_3000),
        .IM_LO   (32'h0000_3000),
        .IM_HI   (32'h0000_6FFC)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory model: word tagged with its own address
    assign bus.f_instr = {16'hC0DE, bus.f_pc[15:0]};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ctl(input logic [1:0] op, input logic judge, input logic [15:0] i16,
                       input logic [25:0] i26, input logic [31:0] rs);
        bus.d_npc_op  = op;
        bus.d_judge   = judge;
        bus.d_imm16   = i16;
        bus.d_imm26   = i26;
        bus.d_rs_data = rs;
    endtask

    task automatic chk_pipe(input string tag, input logic [31:0] pc, input logic [31:0] fpc,
                            input logic [31:0] br, input logic [31:0] tk);
        check({tag, ".f_pc"}, bus.f_pc, pc);
        check({tag, ".fd_pc"}, bus.fd_pc, fpc);
        check({tag, ".br_cnt"}, bus.br_cnt, br);
        check({tag, ".br_taken"}, bus.br_taken_cnt, tk);
    endtask

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        reset     = 1'b0;
        bus.stall = 1'b0;
        ctl(2'd0, 1'b0, 16'h0, 26'h0, 32'h0);
        #12;
        check("rst.f_pc", bus.f_pc, 32'h3000);
        check("rst.f_adel", {31'b0, bus.f_adel}, 32'd0);
        check("rst.fd_valid", {31'b0, bus.fd_valid}, 32'd0);
        check("rst.fd_pc", bus.fd_pc, 32'h0);
        check("rst.fd_instr", bus.fd_instr, 32'h0);
        check("rst.cnt", bus.br_cnt | bus.br_taken_cnt, 32'h0);

        // Branch presented while F/D still holds the reset bubble: ignored
        ctl(2'd1, 1'b1, 16'h0040, 26'h0, 32'h0);
        reset = 1'b1;
        step();
        check("e1.fd_valid", {31'b0, bus.fd_valid}, 32'd1);
        check("e1.fd_instr", bus.fd_instr, 32'hC0DE_3000);
        chk_pipe("e1", 32'h3004, 32'h3000, 0, 0);
        ctl(2'd0, 1'b0, 16'h0, 26'h0, 32'h0);
        step();
        chk_pipe("e2", 32'h3008, 32'h3004, 0, 0);

        // beq taken from 3004, offset 3 -> target 3014; delay slot 3008 kept
        ctl(2'd1, 1'b1, 16'h0003, 26'h0, 32'h0);
        step();
        chk_pipe("beq", 32'h3014, 32'h3008, 1, 1);
        check("beq.slot", bus.fd_instr, 32'hC0DE_3008);
        ctl(2'd0, 1'b0, 16'h0, 26'h0, 32'h0);
        step();
        chk_pipe("tgt", 32'h3018, 32'h3014, 1, 1);

        // Not taken with negative offset, then taken back from 3018 by -2 words
        ctl(2'd1, 1'b0, 16'hFFFF, 26'h0, 32'h0);
        step();
        chk_pipe("bnt", 32'h301C, 32'h3018, 2, 1);
        ctl(2'd1, 1'b1, 16'hFFFE, 26'h0, 32'h0);
        step();
        chk_pipe("bback", 32'h3014, 32'h301C, 3, 2);
        ctl(2'd0, 1'b0, 16'h0, 26'h0, 32'h0);
        step();
        chk_pipe("bback2", 32'h3018, 32'h3014, 3, 2);

        // Taken branch under a 2-cycle stall: frozen, then taken once
        ctl(2'd1, 1'b1, 16'h0010, 26'h0, 32'h0);
        bus.stall = 1'b1;
        step();
        chk_pipe("stl1", 32'h3018, 32'h3014, 3, 2);
        step();
        chk_pipe("stl2", 32'h3018, 32'h3014, 3, 2);
        check("stl2.instr", bus.fd_instr, 32'hC0DE_3014);
        bus.stall = 1'b0;
        step();
        chk_pipe("stlrel", 32'h3058, 32'h3018, 4, 3);
        ctl(2'd0, 1'b0, 16'h0, 26'h0, 32'h0);
        step();
        chk_pipe("stlnext", 32'h305C, 32'h3058, 4, 3);

        // j: region of fd_pc+4 with index 0xC40 -> 0x3100
        ctl(2'd2, 1'b1, 16'h7FFF, 26'h000_0C40, 32'h0);
        step();
        chk_pipe("j", 32'h3100, 32'h305C, 4, 3);
        ctl(2'd0, 1'b0, 16'h0, 26'h0, 32'h0);
        step();
        chk_pipe("j2", 32'h3104, 32'h3100, 4, 3);

        // jr to misaligned address
        ctl(2'd3, 1'b0, 16'h0, 26'h0, 32'h0000_3002);
        step();
        check("jr.f_pc", bus.f_pc, 32'h3002);
        check("jr.f_adel", {31'b0, bus.f_adel}, 32'd1);
        ctl(2'd0, 1'b0, 16'h0, 26'h0, 32'h0);
        step();
        check("jr.fd_pc", bus.fd_pc, 32'h3002);
        check("jr.fd_adel", {31'b0, bus.fd_adel}, 32'd1);
        check("jr.fd_instr", bus.fd_instr, 32'h0);
        check("jr.f_pc2", bus.f_pc, 32'h3006);

        // jr just above IM_HI
        ctl(2'd3, 1'b0, 16'h0, 26'h0, 32'h0000_7000);
        step();
        check("jrhi.f_adel", {31'b0, bus.f_adel}, 32'd1);
        ctl(2'd3, 1'b0, 16'h0, 26'h0, 32'h0000_6FFC);
        step();
        check("jrhi.fd_adel", {31'b0, bus.fd_adel}, 32'd1);
        check("jrhi.fd_instr", bus.fd_instr, 32'h0);
        check("jrtop.f_pc", bus.f_pc, 32'h6FFC);
        check("jrtop.f_adel", {31'b0, bus.f_adel}, 32'd0);
        ctl(2'd0, 1'b0, 16'h0, 26'h0, 32'h0);
        step();
        check("top.fd_instr", bus.fd_instr, 32'hC0DE_6FFC);
        check("top.fd_adel", {31'b0, bus.fd_adel}, 32'd0);
        check("top.f_adel", {31'b0, bus.f_adel}, 32'd1);

        // Asynchronous reset mid-cycle while a taken branch is pending
        ctl(2'd1, 1'b1, 16'h0001, 26'h0, 32'h0);
        #2;
        reset = 1'b0;
        #1;
        chk_pipe("arst", 32'h3000, 32'h0, 0, 0);
        check("arst.fd_valid", {31'b0, bus.fd_valid}, 32'd0);
        check("arst.fd_adel", {31'b0, bus.fd_adel}, 32'd0);
        step();
        chk_pipe("arst.hold", 32'h3000, 32'h0, 0, 0);
        reset = 1'b1;
        step();
        chk_pipe("arst.rel", 32'h3004, 32'h3000, 0, 0);
        check("arst.rel.valid", {31'b0, bus.fd_valid}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
